branch_resolve_unit: RTL and testbench

//  ID-stage branch resolver with a dynamic predictor; next-generation flush unit.
//  IF looks up a 2-bit-counter BHT indexed by PC to predict taken/not-taken.
//  ID compares RS/RT for BEQ/BNE/BLT/BGE and checks the outcome against the prediction carried in IF/ID.
//  On mispredict it flushes IF/ID and redirects the PC; the BHT trains on every resolved branch.

---
 rtl/bru_pkg.sv | 18 +
 rtl/bht_counter_array.sv | 45 ++++
 rtl/branch_resolve_unit.sv | 130 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/bru_pkg.sv
// Shared types and constants for the ID-stage branch resolve unit.
package bru_pkg;

    // Branch kind decoded in ID; encodings 5..7 are treated as NONE
    typedef enum logic [2:0] {
        NONE = 3'd0,
        BEQ  = 3'd1,
        BNE  = 3'd2,
        BLT  = 3'd3,
        BGE  = 3'd4
    } br_type_e;

    // Sequential instruction step in bytes
    localparam int PC_STEP   = 4;
    // Branch immediates count halfwords
    localparam int IMM_SHIFT = 1;

endpackage : bru_pkg

// File: rtl/bht_counter_array.sv
// Branch history table: an array of saturating up/down counters with one
// combinational read port (IF lookup) and one saturating write port (ID train).
// A same-cycle read of the entry being written returns the pre-update value.
module bht_counter_array #(
    parameter int ENTRIES = 64,
    parameter int CNT_W   = 2,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_cnt,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_inc
);

    // Weakly not-taken: MSB clear, all lower bits set
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_MIN  = '0;

    logic [CNT_W-1:0] cnt_q [ENTRIES];
    logic [CNT_W-1:0] wr_cur;

    assign rd_cnt = cnt_q[rd_idx];
    assign wr_cur = cnt_q[wr_idx];

    // Reset every entry to weakly not-taken; otherwise nudge the trained entry toward the outcome
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= CNT_INIT;
            end
        end else if (wr_en) begin
            if (wr_inc) begin
                if (wr_cur != CNT_MAX) cnt_q[wr_idx] <= wr_cur + CNT_ONE;
            end else begin
                if (wr_cur != CNT_MIN) cnt_q[wr_idx] <= wr_cur - CNT_ONE;
            end
        end
    end

endmodule : bht_counter_array

// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolver with a 2-bit-counter dynamic predictor.
// IF reads a prediction for if_pc_i; ID evaluates the branch, flushes IF/ID and
// redirects the PC when the carried prediction was wrong, and trains the BHT.
// Optional build macro: BRU_STATS_EN adds saturating resolved-branch and
// mispredict counters with their two output ports.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] if_pc_i,
    output logic            if_pred_taken_o,
    input  logic            id_valid_i,
    input  logic            id_stall_i,
    input  logic [2:0]      id_br_type_i,
    input  logic [XLEN-1:0] id_pc_i,
    input  logic [XLEN-1:0] id_imm_i,
    input  logic            id_pred_taken_i,
    input  logic [XLEN-1:0] rs_data_i,
    input  logic [XLEN-1:0] rt_data_i,
    output logic            flush_o,
    output logic [XLEN-1:0] redirect_pc_o
`ifdef BRU_STATS_EN
    ,
    output logic [31:0]     branch_cnt_o,
    output logic [31:0]     mispred_cnt_o
`endif
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    // Qualification: an ID instruction is consumed only when id_valid_i=1 and
    // id_stall_i=0 in the same cycle. A stalled branch is re-presented unchanged,
    // so it resolves, flushes and trains exactly once, in its release cycle.
    logic            is_branch;
    logic            taken;
    logic            resolve;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] fall_through;
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] id_idx;
    logic [CNT_W-1:0] if_cnt;

    // PC bits outside the index field do not affect the predictor
    logic unused_if_pc;
    assign unused_if_pc = ^{if_pc_i[XLEN-1:IDX_W+2], if_pc_i[1:0]};

    // Decode the branch kind and evaluate its condition; unknown encodings are not branches
    always_comb begin
        is_branch = 1'b0;
        taken     = 1'b0;
        case (id_br_type_i)
            BEQ: begin
                is_branch = 1'b1;
                taken     = (rs_data_i == rt_data_i);
            end
            BNE: begin
                is_branch = 1'b1;
                taken     = (rs_data_i != rt_data_i);
            end
            BLT: begin
                is_branch = 1'b1;
                taken     = ($signed(rs_data_i) < $signed(rt_data_i));
            end
            BGE: begin
                is_branch = 1'b1;
                taken     = !($signed(rs_data_i) < $signed(rt_data_i));
            end
            default: begin
                is_branch = 1'b0;
                taken     = 1'b0;
            end
        endcase
    end

    // Reset masks resolution so flush/redirect drop the instant rst_i rises
    assign resolve = ~rst_i & id_valid_i & ~id_stall_i & is_branch;

    assign target       = id_pc_i + (id_imm_i << IMM_SHIFT);
    assign fall_through = id_pc_i + XLEN'(PC_STEP);

    assign flush_o       = resolve & (taken != id_pred_taken_i);
    assign redirect_pc_o = flush_o ? (taken ? target : fall_through) : '0;

    assign if_idx = if_pc_i[IDX_W+1:2];
    assign id_idx = id_pc_i[IDX_W+1:2];

    bht_counter_array #(
        .ENTRIES (BHT_ENTRIES),
        .CNT_W   (CNT_W)
    ) u_bht (
        .clk    (clk_i),
        .rst    (rst_i),
        .rd_idx (if_idx),
        .rd_cnt (if_cnt),
        .wr_en  (resolve),
        .wr_idx (id_idx),
        .wr_inc (taken)
    );

    assign if_pred_taken_o = if_cnt[CNT_W-1];

`ifdef BRU_STATS_EN
    logic [31:0] branch_cnt_q;
    logic [31:0] mispred_cnt_q;

    // Count resolved branches and mispredicts, holding at all-ones
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (resolve && (branch_cnt_q != 32'hFFFF_FFFF)) begin
                branch_cnt_q <= branch_cnt_q + 32'd1;
            end
            if (flush_o && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
                mispred_cnt_q <= mispred_cnt_q + 32'd1;
            end
        end
    end

    assign branch_cnt_o  = branch_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;
`endif

endmodule : branch_resolve_unit

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit. Each driven cycle pushes the
// hand-computed {flush, redirect, if_pred} triple; a negedge monitor pops it.
module tb_branch_resolve_unit;

    localparam int W = 34;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] if_pc = '0;
    logic        if_pred;
    logic        id_valid = 1'b0;
    logic        id_stall = 1'b0;
    logic [2:0]  id_type = '0;
    logic [31:0] id_pc = '0;
    logic [31:0] id_imm = '0;
    logic        id_pred = 1'b0;
    logic [31:0] rs = '0;
    logic [31:0] rt = '0;
    logic        flush;
    logic [31:0] redirect;
`ifdef BRU_STATS_EN
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;
`endif

    logic         chk_en = 1'b0;
    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_fails  = 0;
    int           vec_id   = 0;

    branch_resolve_unit dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .if_pc_i         (if_pc),
        .if_pred_taken_o (if_pred),
        .id_valid_i      (id_valid),
        .id_stall_i      (id_stall),
        .id_br_type_i    (id_type),
        .id_pc_i         (id_pc),
        .id_imm_i        (id_imm),
        .id_pred_taken_i (id_pred),
        .rs_data_i       (rs),
        .rt_data_i       (rt),
        .flush_o         (flush),
        .redirect_pc_o   (redirect)
`ifdef BRU_STATS_EN
        ,
        .branch_cnt_o    (branch_cnt),
        .mispred_cnt_o   (mispred_cnt)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    // Apply one cycle of inputs just after the rising edge and queue its expectation
    task automatic drive(input logic r, input logic v, input logic s, input logic [2:0] t,
                         input logic [31:0] pc, input logic [31:0] imm, input logic p,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] ifpc,
                         input logic ef, input logic [31:0] er, input logic ep);
        @(posedge clk);
        #1;
        rst      = r;
        id_valid = v;
        id_stall = s;
        id_type  = t;
        id_pc    = pc;
        id_imm   = imm;
        id_pred  = p;
        rs       = a;
        rt       = b;
        if_pc    = ifpc;
        chk_en   = 1'b1;
        exp_q.push_back({ef, er, ep});
    endtask

    // Idle ID stage, IF lookup only
    task automatic lookup(input logic [31:0] ifpc, input logic ep);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, ifpc, 1'b0, 32'h0, ep);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [W-1:0] got;
        if (chk_en) begin
            n_checks++;
            vec_id++;
            got = {flush, redirect, if_pred};
            if (exp_q.size() == 0) begin
                n_fails++;
                $display("FAIL vec%0d queue_empty: got %h, no expected entry", vec_id, got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_fails++;
                    $display("FAIL vec%0d {flush,redirect,pred}: got %0b/%h/%0b expected %0b/%h/%0b",
                             vec_id, got[33], got[32:1], got[0], e[33], e[32:1], e[0]);
                end
            end
        end
    end

    initial begin
        #2 rst = 1'b1;

        // Reset state
        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h40, 1'b0, 32'h0, 1'b0);

        // 1: taken BEQ predicted NT -> flush to 0x50, then IF at 0x40 predicts taken
        drive(1'b0, 1'b1, 1'b0, 3'd1, 32'h40, 32'h8, 1'b0, 32'd5, 32'd5, 32'h40, 1'b1, 32'h50, 1'b0);
        lookup(32'h40, 1'b1);

        // 2: NT BNE twice at 0x80 (1->0->0), then taken -> 1, still predicts NT
        drive(1'b0, 1'b1, 1'b0, 3'd2, 32'h80, 32'h4, 1'b0, 32'd7, 32'd7, 32'h80, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 3'd2, 32'h80, 32'h4, 1'b0, 32'd7, 32'd7, 32'h80, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 3'd1, 32'h80, 32'h2, 1'b0, 32'd7, 32'd7, 32'h80, 1'b1, 32'h84, 1'b0);
        lookup(32'h80, 1'b0);

        // 3: signed compares, target wrap, unused encodings
        drive(1'b0, 1'b1, 1'b0, 3'd3, 32'h100, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b1, 32'hF8, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 3'd4, 32'h104, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0, 32'h0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 3'd4, 32'h108, 32'h20, 1'b0, 32'd5, 32'd3, 32'h40, 1'b1, 32'h148, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 3'd2, 32'h10C, 32'h20, 1'b1, 32'd1, 32'd2, 32'h40, 1'b0, 32'h0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 3'd3, 32'h110, 32'h20, 1'b1, 32'd9, 32'd9, 32'h40, 1'b1, 32'h114, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 3'd4, 32'h118, 32'h20, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 32'h40, 1'b1, 32'h11C, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 3'd1, 32'hFFFF_FFF0, 32'h10, 1'b0, 32'd3, 32'd3, 32'h40, 1'b1, 32'h10, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 3'd5, 32'h120, 32'h10, 1'b0, 32'd3, 32'd3, 32'h40, 1'b0, 32'h0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 3'd0, 32'h124, 32'h10, 1'b1, 32'd3, 32'd4, 32'h40, 1'b0, 32'h0, 1'b1);

        // 4: taken BEQ at 0x2E0 stalled 3 cycles, released, then one NT to prove single training
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b1, 3'd1, 32'h2E0, 32'h10, 1'b0, 32'd2, 32'd2, 32'h2E0, 1'b0, 32'h0, 1'b0);
        end
        drive(1'b0, 1'b1, 1'b0, 3'd1, 32'h2E0, 32'h10, 1'b0, 32'd2, 32'd2, 32'h2E0, 1'b1, 32'h300, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 3'd2, 32'h2E0, 32'h10, 1'b1, 32'd2, 32'd2, 32'h2E0, 1'b1, 32'h2E4, 1'b1);
        lookup(32'h2E0, 1'b0);

        // 5: same-cycle lookup/update of index 5 sees old value; alias 0x114 sees new
        drive(1'b0, 1'b1, 1'b0, 3'd1, 32'h14, 32'h8, 1'b0, 32'd3, 32'd3, 32'h14, 1'b1, 32'h24, 1'b0);
        lookup(32'h114, 1'b1);
        // Reset mid-stream with a mispredicting branch present
        drive(1'b1, 1'b1, 1'b0, 3'd1, 32'h40, 32'h8, 1'b0, 32'd5, 32'd5, 32'h14, 1'b0, 32'h0, 1'b0);
        lookup(32'h40, 1'b0);
        lookup(32'h14, 1'b0);

        // Statistics workload: 10 resolved branches, mispredicts at i=0,3,6
        for (int i = 0; i < 10; i++) begin
            logic        tk;
            logic        mis;
            logic [31:0] pc;
            logic [31:0] er;
            tk  = (i % 2 == 0);
            mis = (i % 3 == 0) && (i < 9);
            pc  = 32'h304 + 32'(4 * i);
            er  = mis ? (tk ? pc + 32'd8 : pc + 32'd4) : 32'h0;
            drive(1'b0, 1'b1, 1'b0, tk ? 3'd1 : 3'd2, pc, 32'h4, tk ^ mis, 32'd6, 32'd6, 32'h0, mis, er, 1'b0);
            if (i == 4) begin
                // Stalled mispredicting branch and a non-branch must not count
                drive(1'b0, 1'b1, 1'b1, 3'd1, 32'h3F0, 32'h4, 1'b0, 32'd6, 32'd6, 32'h0, 1'b0, 32'h0, 1'b0);
                drive(1'b0, 1'b1, 1'b0, 3'd0, 32'h3F4, 32'h4, 1'b1, 32'd6, 32'd6, 32'h0, 1'b0, 32'h0, 1'b0);
            end
        end

        @(posedge clk);
        #1;
        chk_en   = 1'b0;
        id_valid = 1'b0;
        @(negedge clk);

`ifdef BRU_STATS_EN
        n_checks++;
        if (branch_cnt !== 32'd10) begin
            n_fails++;
            $display("FAIL branch_cnt: got %0d expected %0d", branch_cnt, 10);
        end
        n_checks++;
        if (mispred_cnt !== 32'd3) begin
            n_fails++;
            $display("FAIL mispred_cnt: got %0d expected %0d", mispred_cnt, 3);
        end
`endif

        // Bounded drain of the scoreboard
        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_branch_resolve_unit
